// File: rtl/branch_pkg.sv
// branch_pkg: branch op encodings, FSM state type and counter width default
package branch_pkg;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [2:0] {
    BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ, BR_BLT, BR_BLTU
  } br_op_e;
  typedef enum logic {EMPTY, FULL} br_state_e;
endpackage

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: request/result handshake between datapath, resolver and fetch
interface branch_resolve_if;
  logic in_valid, in_ready, out_valid, out_ready;
  logic big, equal, little, sign1, sign2, taken, err;
  logic [2:0] op;
  logic [31:0] pc, target;
  logic [15:0] offset;
  modport master(
    output in_valid, op, big, equal, little, sign1, sign2, pc, offset, out_ready,
    input in_ready, out_valid, taken, target, err
  );
  modport slave(
    input in_valid, op, big, equal, little, sign1, sign2, pc, offset, out_ready,
    output in_ready, out_valid, taken, target, err
  );
endinterface

// File: rtl/branch_cond.sv
// branch_cond: branch condition from unsigned comparator flags and operand signs
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] op,
  input  logic       big,
  input  logic       equal,
  input  logic       little,
  input  logic       sign1,
  input  logic       sign2,
  output logic       taken,
  output logic       err
);
  logic s_big, s_little, cond;
  assign s_little = (sign1 != sign2) ? sign1 : little;
  assign s_big    = (sign1 != sign2) ? sign2 : big;
  assign err      = $countones({big, equal, little}) != 1;
  always_comb begin
    cond = 1'b0;
    case (br_op_e'(op))
      BR_BEQ:  cond = equal;
      BR_BNE:  cond = !equal;
      BR_BLEZ: cond = s_little | equal;
      BR_BGTZ: cond = s_big;
      BR_BLTZ: cond = s_little;
      BR_BGEZ: cond = s_big | equal;
      BR_BLT:  cond = s_little;
      BR_BLTU: cond = little;
      default: cond = 1'b0;
    endcase
  end
  assign taken = cond & !err;
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: registered branch resolution with valid/ready handshake and statistics
module branch_resolve
  import branch_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_resolve_if.slave  bus,
  output logic [CNT_W-1:0] resolved_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  br_state_e state, next;
  logic accept, c_taken, c_err;
  logic [31:0] seq_pc, br_pc;
  branch_cond u_cond (
    .op(bus.op), .big(bus.big), .equal(bus.equal), .little(bus.little),
    .sign1(bus.sign1), .sign2(bus.sign2), .taken(c_taken), .err(c_err)
  );
  assign accept = bus.in_valid & bus.in_ready;
  assign seq_pc = bus.pc + 32'd4;
  assign br_pc  = seq_pc + {{14{bus.offset[15]}}, bus.offset, 2'b00};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= next;
  always_comb next = accept ? FULL : (state == FULL && bus.out_ready) ? EMPTY : state;
  always_comb begin
    bus.in_ready  = (state == EMPTY) | bus.out_ready;
    bus.out_valid = state == FULL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.taken    <= 1'b0;
      bus.target   <= '0;
      bus.err      <= 1'b0;
      resolved_cnt <= '0;
      taken_cnt    <= '0;
    end else if (accept) begin
      bus.taken    <= c_taken;
      bus.target   <= c_taken ? br_pc : seq_pc;
      bus.err      <= c_err;
      resolved_cnt <= resolved_cnt + CNT_W'(~&resolved_cnt);
      taken_cnt    <= taken_cnt + CNT_W'(c_taken & ~&taken_cnt);
    end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: table vectors through a scoreboard plus stall, saturation and reset sequences
module tb_branch_resolve;
  import branch_pkg::*;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  typedef struct {
    logic [2:0]  op;
    logic        big, equal, little, s1, s2;
    logic [31:0] pc;
    logic [15:0] off;
    logic        exp_taken;
    logic [31:0] exp_target;
    logic        exp_err;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [CNT_W-1:0] resolved_cnt, taken_cnt;
  branch_resolve_if bus();
  branch_resolve #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .resolved_cnt(resolved_cnt), .taken_cnt(taken_cnt)
  );
  always #5 clk = ~clk;
  vec_t vt[19];
  vec_t q[$];
  int n_vec = 0, n_miss = 0, acc = 0, tk = 0;
  function automatic vec_t mk(logic [2:0] op, logic b, logic e, logic l, logic s1, logic s2,
                              logic [31:0] pc, logic [15:0] off, logic t, logic [31:0] tgt, logic er);
    vec_t v;
    v.op = op; v.big = b; v.equal = e; v.little = l; v.s1 = s1; v.s2 = s2;
    v.pc = pc; v.off = off; v.exp_taken = t; v.exp_target = tgt; v.exp_err = er;
    return v;
  endfunction
  function automatic int sat(int n);
    return n > CMAX ? CMAX : n;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic iv, input vec_t v, input logic ordy, output logic ok);
    vec_t e;
    @(negedge clk);
    bus.in_valid = iv; bus.op = v.op; bus.big = v.big; bus.equal = v.equal;
    bus.little = v.little; bus.sign1 = v.s1; bus.sign2 = v.s2;
    bus.pc = v.pc; bus.offset = v.off; bus.out_ready = ordy;
    #1;
    if (bus.out_valid && ordy) begin
      chk("unexpected_output", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("taken", bus.taken, e.exp_taken);
        chk("target", bus.target, e.exp_target);
        chk("err", bus.err, e.exp_err);
      end
    end
    ok = iv && bus.in_ready;
    if (ok) begin
      q.push_back(v);
      acc++;
      if (v.exp_taken) tk++;
    end
  endtask
  task automatic send(input vec_t v, input bit rnd);
    logic ok;
    int n = 0;
    do begin
      step(1'b1, v, rnd ? logic'($urandom_range(0, 3) != 0) : 1'b1, ok);
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", 0, 1);
  endtask
  task automatic drain();
    logic ok;
    int n = 0;
    while (q.size() > 0 && n < 30) begin
      step(1'b0, vt[0], 1'b1, ok);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask
  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_taken", bus.taken, 0);
    chk("rst_target", bus.target, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_resolved", resolved_cnt, 0);
    chk("rst_taken_cnt", taken_cnt, 0);
    q.delete();
    acc = 0;
    tk = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic ok;
    vt[0]  = mk(BR_BEQ,  0,1,0, 0,0, 32'h0000_0100, 16'h0004, 1, 32'h0000_0114, 0);
    vt[1]  = mk(BR_BEQ,  1,0,0, 0,0, 32'h0000_0100, 16'h0004, 0, 32'h0000_0104, 0);
    vt[2]  = mk(BR_BNE,  1,0,0, 0,0, 32'hFFFF_FFF8, 16'h0001, 1, 32'h0000_0000, 0);
    vt[3]  = mk(BR_BNE,  0,1,0, 0,0, 32'h0000_0200, 16'h0004, 0, 32'h0000_0204, 0);
    vt[4]  = mk(BR_BLT,  1,0,0, 1,0, 32'h0000_1000, 16'hFFFF, 1, 32'h0000_1000, 0);
    vt[5]  = mk(BR_BLTU, 1,0,0, 1,0, 32'h0000_1000, 16'hFFFF, 0, 32'h0000_1004, 0);
    vt[6]  = mk(BR_BLEZ, 1,0,0, 1,0, 32'h0000_2000, 16'h0010, 1, 32'h0000_2044, 0);
    vt[7]  = mk(BR_BLEZ, 0,1,0, 0,0, 32'h0000_3000, 16'h8000, 1, 32'hFFFE_3004, 0);
    vt[8]  = mk(BR_BGTZ, 1,0,0, 0,0, 32'h0000_0040, 16'h0002, 1, 32'h0000_004C, 0);
    vt[9]  = mk(BR_BGTZ, 1,0,0, 1,0, 32'h0000_0040, 16'h0002, 0, 32'h0000_0044, 0);
    vt[10] = mk(BR_BLTZ, 1,0,0, 1,0, 32'h0000_0080, 16'h0001, 1, 32'h0000_0088, 0);
    vt[11] = mk(BR_BGEZ, 0,1,0, 0,0, 32'h0000_0080, 16'h0001, 1, 32'h0000_0088, 0);
    vt[12] = mk(BR_BGEZ, 1,0,0, 1,0, 32'h0000_0080, 16'h0001, 0, 32'h0000_0084, 0);
    vt[13] = mk(BR_BLT,  0,0,1, 0,0, 32'h0000_0000, 16'h0003, 1, 32'h0000_0010, 0);
    vt[14] = mk(BR_BLT,  0,0,1, 0,1, 32'h0000_0000, 16'h0003, 0, 32'h0000_0004, 0);
    vt[15] = mk(BR_BLTU, 0,0,1, 0,1, 32'h0000_0000, 16'h0003, 1, 32'h0000_0010, 0);
    vt[16] = mk(BR_BNE,  1,0,1, 0,0, 32'h0000_0500, 16'h0004, 0, 32'h0000_0504, 1);
    vt[17] = mk(BR_BEQ,  0,0,0, 0,0, 32'h0000_0600, 16'h0004, 0, 32'h0000_0604, 1);
    vt[18] = mk(BR_BLT,  0,0,1, 1,1, 32'h0000_0010, 16'h0000, 1, 32'h0000_0014, 0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.big = 1'b0; bus.equal = 1'b0;
    bus.little = 1'b0; bus.sign1 = 1'b0; bus.sign2 = 1'b0; bus.pc = '0; bus.offset = '0;
    rst_pulse();
    foreach (vt[i]) send(vt[i], 1'b1);
    drain();
    chk("resolved_after_table", resolved_cnt, sat(acc));
    chk("taken_after_table", taken_cnt, sat(tk));
    rst_pulse();
    step(1'b1, vt[0], 1'b1, ok);
    chk("stall_first_accept", ok, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, vt[2], 1'b0, ok);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_target", bus.target, vt[0].exp_target);
      chk("stall_taken", bus.taken, vt[0].exp_taken);
      chk("stall_resolved", resolved_cnt, 1);
    end
    step(1'b1, vt[2], 1'b1, ok);
    chk("back_to_back_accept", ok, 1);
    step(1'b1, vt[16], 1'b1, ok);
    chk("back_to_back_accept2", ok, 1);
    drain();
    chk("resolved_after_stall", resolved_cnt, 3);
    chk("taken_after_stall", taken_cnt, 2);
    rst_pulse();
    for (int i = 0; i < 20; i++) send(vt[0], 1'b0);
    drain();
    chk("resolved_saturated", resolved_cnt, CMAX);
    chk("taken_saturated", taken_cnt, CMAX);
    step(1'b1, vt[8], 1'b0, ok);
    step(1'b0, vt[8], 1'b0, ok);
    chk("full_before_reset", bus.out_valid, 1);
    rst_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
